pe_array_seq: RTL and testbench

Tile sequencer for the output-stationary N×N systolic array built from PE_D diagonal elements.
- Accepts a start command with the reduction length and BRAM base addresses.
- Issues ifmap and weight BRAM reads, then drives the array control signals in this order: clear, feed, skew flush, row-by-row output ejection.
- Ejected rows leave over a valid/ready handshake to the downstream writeback.
- Sits between the layer controller (start/done) and the PE array plus its input muxes.

---
 rtl/pe_array_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_pe_array_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_seq.sv
// -----------------------------------------------------------------------------
// pe_array_seq
//
// Tile sequencer for an output-stationary N x N systolic array of PE_D
// diagonal elements. One accepted start command runs one tile:
//
//   IDLE -> CLEAR -> FEED (K cycles) -> FLUSH (2N-2) -> SETTLE -> EJECT -> DONE
//
// A tile with K = 0 skips FEED, FLUSH and SETTLE. The array then ejects the
// zeros left by the clear, and no BRAM reads are issued.
//
// The BRAM read latency is one cycle. For that reason the array-side enables
// are registered copies of the FSM phase, so they line up with the read data.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               command strobe, sampled only in IDLE
//   cfg_k               reduction length K (number of MAC steps)
//   cfg_ifmap_base      first ifmap BRAM address
//   cfg_weight_base     first weight BRAM address
//   busy                high in every state except IDLE
//   done                one-cycle pulse when a tile completes
//   ifmap_rd_en/addr    ifmap BRAM read port
//   weight_rd_en/addr   weight BRAM read port
//   en_in, en_psum      array input-register / accumulate enables
//   clear_psum          array accumulator clear
//   en_out              array output shift enable (the handshake itself)
//   ifmap_sel_ctrl      per-diagonal source select, 1 = BRAM, 0 = neighbour
//   feed_zero           edge muxes inject zeros while the wavefront flushes
//   output_eject_ctrl   array is in output-passing mode
//   out_valid/ready     row handshake towards writeback
//   out_row             index of the row currently presented
// -----------------------------------------------------------------------------
module pe_array_seq #(
  parameter int N  = 4,
  parameter int KW = 10,
  parameter int AW = 10,
  parameter int RW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] cfg_k,
  input  logic [AW-1:0] cfg_ifmap_base,
  input  logic [AW-1:0] cfg_weight_base,
  output logic          busy,
  output logic          done,
  output logic          ifmap_rd_en,
  output logic [AW-1:0] ifmap_rd_addr,
  output logic          weight_rd_en,
  output logic [AW-1:0] weight_rd_addr,
  output logic          en_in,
  output logic          en_psum,
  output logic          clear_psum,
  output logic          en_out,
  output logic [N-1:0]  ifmap_sel_ctrl,
  output logic          feed_zero,
  output logic          output_eject_ctrl,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_row
);

  // The flush counter runs 0 .. 2N-3, so it needs clog2(2N-1) bits.
  localparam int            FW         = $clog2(2 * N - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 3);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_SETTLE,
    S_EJECT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;

  // Command latched at start. The cfg_* inputs are not looked at again
  // until the next accepted start.
  logic [KW-1:0] k_q;
  logic [AW-1:0] ifmap_addr_q;
  logic [AW-1:0] weight_addr_q;

  logic [KW-1:0] step_q;
  logic [FW-1:0] flush_q;
  logic [RW-1:0] row_q;

  // The array-side controls trail the FSM by one cycle because of the
  // BRAM read latency.
  logic          win_d_q;    // previous state was FEED or FLUSH
  logic          feed_d_q;   // previous state was FEED
  logic          flush_d_q;  // previous state was FLUSH

  logic          last_step;
  logic          last_flush;
  logic          last_row;
  logic          xfer;

  assign last_step  = (step_q == k_q - KW'(1));
  assign last_flush = (flush_q == FLUSH_LAST);
  assign last_row   = (row_q == ROW_LAST);
  assign xfer       = (state_q == S_EJECT) && out_ready;

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every
  // register samples the pre-edge values, so the order of statements in
  // this block cannot change what is stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      ifmap_addr_q  <= '0;
      weight_addr_q <= '0;
      step_q        <= '0;
      flush_q       <= '0;
      row_q         <= '0;
      win_d_q       <= 1'b0;
      feed_d_q      <= 1'b0;
      flush_d_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_d_q   <= (state_q == S_FEED) || (state_q == S_FLUSH);
      feed_d_q  <= (state_q == S_FEED);
      flush_d_q <= (state_q == S_FLUSH);

      case (state_q)
        S_IDLE: begin
          if (start) begin
            k_q           <= cfg_k;
            ifmap_addr_q  <= cfg_ifmap_base;
            weight_addr_q <= cfg_weight_base;
            step_q        <= '0;
            flush_q       <= '0;
            row_q         <= '0;
          end
        end
        S_FEED: begin
          // The addresses wrap modulo 2^AW by design.
          step_q        <= step_q + KW'(1);
          ifmap_addr_q  <= ifmap_addr_q + AW'(1);
          weight_addr_q <= weight_addr_q + AW'(1);
        end
        S_FLUSH: begin
          flush_q <= flush_q + FW'(1);
        end
        S_EJECT: begin
          // Return to row 0 explicitly, so that N need not be a power of two.
          if (xfer) begin
            row_q <= last_row ? '0 : row_q + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default value first. Then no path
  // through the case leaves a signal unassigned, so no latch is inferred.
  always_comb begin
    state_d           = state_q;
    busy              = (state_q != S_IDLE);
    done              = 1'b0;
    clear_psum        = 1'b0;
    ifmap_rd_en       = 1'b0;
    weight_rd_en      = 1'b0;
    ifmap_rd_addr     = '0;
    weight_rd_addr    = '0;
    output_eject_ctrl = 1'b0;
    out_valid         = 1'b0;
    en_out            = 1'b0;
    en_in             = win_d_q;
    en_psum           = win_d_q;
    ifmap_sel_ctrl    = {N{feed_d_q}};
    feed_zero         = flush_d_q;
    out_row           = row_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clear_psum = 1'b1;
        state_d    = (k_q == '0) ? S_EJECT : S_FEED;
      end
      S_FEED: begin
        ifmap_rd_en    = 1'b1;
        weight_rd_en   = 1'b1;
        ifmap_rd_addr  = ifmap_addr_q;
        weight_rd_addr = weight_addr_q;
        if (last_step) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (last_flush) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        // This extra cycle lets the last delayed en_in drop before
        // output_eject_ctrl rises, so the two are never high together.
        state_d = S_EJECT;
      end
      S_EJECT: begin
        output_eject_ctrl = 1'b1;
        out_valid         = 1'b1;
        en_out            = out_ready;
        if (xfer && last_row) state_d = S_DONE;
      end
      S_DONE: begin
        // A start seen in this cycle is ignored. It is taken in IDLE at
        // the earliest.
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_array_seq.sv
// -----------------------------------------------------------------------------
// tb_pe_array_seq
//
// Self-checking bench for pe_array_seq. The reference model describes a tile
// by the cycle index since start was accepted (1 = CLEAR) and by the number of
// rows handed over so far. Every expected output comes from the interval in
// which that output is high.
// -----------------------------------------------------------------------------
module tb_pe_array_seq;

  localparam int N  = 4;
  localparam int KW = 10;
  localparam int AW = 10;
  localparam int RW = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [KW-1:0] cfg_k;
  logic [AW-1:0] cfg_ifmap_base;
  logic [AW-1:0] cfg_weight_base;
  logic          busy;
  logic          done;
  logic          ifmap_rd_en;
  logic [AW-1:0] ifmap_rd_addr;
  logic          weight_rd_en;
  logic [AW-1:0] weight_rd_addr;
  logic          en_in;
  logic          en_psum;
  logic          clear_psum;
  logic          en_out;
  logic [N-1:0]  ifmap_sel_ctrl;
  logic          feed_zero;
  logic          output_eject_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_row;

  pe_array_seq #(.N(N), .KW(KW), .AW(AW), .RW(RW)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .cfg_k             (cfg_k),
    .cfg_ifmap_base    (cfg_ifmap_base),
    .cfg_weight_base   (cfg_weight_base),
    .busy              (busy),
    .done              (done),
    .ifmap_rd_en       (ifmap_rd_en),
    .ifmap_rd_addr     (ifmap_rd_addr),
    .weight_rd_en      (weight_rd_en),
    .weight_rd_addr    (weight_rd_addr),
    .en_in             (en_in),
    .en_psum           (en_psum),
    .clear_psum        (clear_psum),
    .en_out            (en_out),
    .ifmap_sel_ctrl    (ifmap_sel_ctrl),
    .feed_zero         (feed_zero),
    .output_eject_ctrl (output_eject_ctrl),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_row           (out_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit          m_active;
  bit          m_just_reset;
  int          m_rel;
  int          m_k;
  int          m_xfers;
  int          m_ib;
  int          m_wb;

  bit          e_busy, e_clear, e_feed, e_win, e_sel, e_fz, e_ej, e_done, e_en_out;
  logic [AW-1:0] e_iaddr, e_waddr;

  int          dut_dones;
  int          model_dones;

  task automatic model_expect(input bit rdy);
    int eject_from;
    bool_block: begin
      eject_from = (m_k > 0) ? m_k + 2 * N + 1 : 2;
      e_busy   = m_active;
      e_clear  = m_active && m_rel == 1;
      e_feed   = m_active && m_k > 0 && m_rel >= 2 && m_rel <= m_k + 1;
      e_win    = m_active && m_k > 0 && m_rel >= 3 && m_rel <= m_k + 2 * N;
      e_sel    = m_active && m_k > 0 && m_rel >= 3 && m_rel <= m_k + 2;
      e_fz     = m_active && m_k > 0 && m_rel >= m_k + 3 && m_rel <= m_k + 2 * N;
      e_ej     = m_active && m_rel >= eject_from && m_xfers < N;
      e_done   = m_active && m_xfers == N;
      e_en_out = e_ej && rdy;
      e_iaddr  = AW'((m_ib + m_rel - 2) % (1 << AW));
      e_waddr  = AW'((m_wb + m_rel - 2) % (1 << AW));
    end
  endtask

  // Runs one clock cycle. Inputs are applied just after the rising edge, the
  // outputs are compared on the falling edge, and the model advances on the
  // next rising edge.
  task automatic cycle(input bit st, input int k, input int ib, input int wb,
                       input bit rdy, input bit rs);
    start           = st;
    cfg_k           = KW'(k);
    cfg_ifmap_base  = AW'(ib);
    cfg_weight_base = AW'(wb);
    out_ready       = rdy;
    rst             = rs;
    model_expect(rdy);
    @(negedge clk);
    if (m_just_reset) begin
      check("reset_outputs",
            {busy, done, ifmap_rd_en, weight_rd_en, en_in, en_psum, clear_psum,
             en_out, feed_zero, output_eject_ctrl, out_valid},
            32'd0);
      check("reset_vectors", {ifmap_rd_addr, weight_rd_addr, ifmap_sel_ctrl, out_row}, 32'd0);
    end
    check("busy",        busy,        e_busy);
    check("done",        done,        e_done);
    check("clear_psum",  clear_psum,  e_clear);
    check("ifmap_rd_en", ifmap_rd_en, e_feed);
    check("weight_rd_en", weight_rd_en, e_feed);
    if (e_feed) begin
      check("ifmap_rd_addr",  ifmap_rd_addr,  e_iaddr);
      check("weight_rd_addr", weight_rd_addr, e_waddr);
    end
    check("en_in",          en_in,          e_win);
    check("en_psum",        en_psum,        e_win);
    check("ifmap_sel_ctrl", ifmap_sel_ctrl, {N{e_sel}});
    check("feed_zero",      feed_zero,      e_fz);
    check("eject_ctrl",     output_eject_ctrl, e_ej);
    check("out_valid",      out_valid,      e_ej);
    check("en_out",         en_out,         e_en_out);
    if (e_ej) check("out_row", out_row, m_xfers);
    check("in_eject_excl",  en_in & output_eject_ctrl, 1'b0);
    if (done === 1'b1) dut_dones++;
    if (e_done) model_dones++;
    @(posedge clk);
    if (rs) begin
      m_active     = 1'b0;
      m_xfers      = 0;
      m_just_reset = 1'b1;
    end else begin
      m_just_reset = 1'b0;
      if (!m_active) begin
        if (st) begin
          m_active = 1'b1;
          m_rel    = 1;
          m_k      = k;
          m_ib     = ib;
          m_wb     = wb;
          m_xfers  = 0;
        end
      end else if (e_done) begin
        m_active = 1'b0;
      end else begin
        if (e_ej && rdy) m_xfers++;
        m_rel++;
      end
    end
    #1;
  endtask

  // Starts a tile and runs it until the model goes idle.
  // out_ready is held low for tile cycles stall_lo..stall_hi, or is random
  // when rnd_ready is set. With noise set, spurious start pulses carrying a
  // different configuration are driven while the tile is busy, and always in
  // the DONE cycle. rst is raised in tile cycle rst_at (0 = never).
  task automatic run_tile(input int k, input int ib, input int wb,
                          input int stall_lo, input int stall_hi,
                          input bit rnd_ready, input bit noise, input int rst_at);
    int  n;
    bit  rdy, st, rs;
    dut_dones   = 0;
    model_dones = 0;
    cycle(1'b1, k, ib, wb, 1'b1, 1'b0);
    n = 0;
    while (m_active && n < 2000) begin
      rdy = rnd_ready ? ($urandom_range(0, 3) != 0)
                      : !(m_rel >= stall_lo && m_rel <= stall_hi);
      st  = noise && (($urandom_range(0, 2) == 0) || m_xfers == N);
      rs  = (m_rel == rst_at);
      cycle(st, $urandom_range(0, 20), $urandom_range(0, 1023),
            $urandom_range(0, 1023), rdy, rs);
      n++;
    end
    check("tile_timeout", n < 2000, 1'b1);
    check("done_pulses", dut_dones, model_dones);
  endtask

  initial begin
    start           = 1'b0;
    cfg_k           = '0;
    cfg_ifmap_base  = '0;
    cfg_weight_base = '0;
    out_ready       = 1'b0;
    rst             = 1'b1;
    m_active        = 1'b0;
    m_xfers         = 0;
    m_rel           = 0;
    m_k             = 0;
    m_ib            = 0;
    m_wb            = 0;
    @(posedge clk);
    #1;
    m_just_reset = 1'b1;
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Basic tile with out_ready held high.
    run_tile(3, 'h010, 'h200, 0, -1, 1'b0, 1'b0, 0);
    check("basic_done_count", dut_dones, 1);
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);

    // Downstream stall for tile cycles 13..15.
    run_tile(3, 'h010, 'h200, 13, 15, 1'b0, 1'b0, 0);
    // K = 0: the array ejects the cleared zeros.
    run_tile(0, 'h123, 'h321, 0, -1, 1'b0, 1'b0, 0);
    // Address wrap-around.
    run_tile(4, 'h3FE, 'h3FF, 0, -1, 1'b0, 1'b0, 0);
    // Spurious starts while busy and in DONE, then a new configuration.
    run_tile(5, 'h040, 'h080, 0, -1, 1'b1, 1'b1, 0);
    check("noise_done_count", dut_dones, 1);
    run_tile(2, 'h100, 'h101, 0, -1, 1'b0, 1'b0, 0);
    // Reset in FLUSH, then a fresh tile.
    run_tile(3, 'h010, 'h200, 0, -1, 1'b0, 1'b0, 7);
    check("reset_no_done", dut_dones, 0);
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
    run_tile(3, 'h010, 'h200, 0, -1, 1'b0, 1'b0, 0);

    // Random tiles.
    for (int t = 0; t < 30; t++) begin
      run_tile($urandom_range(0, 12), $urandom_range(0, 1023), $urandom_range(0, 1023),
               0, -1, 1'b1, 1'b1,
               ($urandom_range(0, 7) == 0) ? $urandom_range(1, 24) : 0);
      if ($urandom_range(0, 1) == 0) cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
